// File: rtl/exc_sequencer.sv
// Exception/interrupt entry and ERET sequencer: drains the bus, pulses EXL, redirects the PC.
// Entry takes DRAIN(>=1) + ENTER + REDIR cycles with the front end stalled; ERET takes a single RET cycle.
module exc_sequencer #(
    parameter logic [29:0] HANDLER_PC    = 30'h1060,
    parameter int          DRAIN_TIMEOUT = 15,
    parameter int          CNT_W         = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        int_req,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code_in,
    input  logic        eret,
    input  logic        mem_idle,
    input  logic [29:0] epc,
    output logic        stall,
    output logic        flush,
    output logic        exl_set,
    output logic        exl_clr,
    output logic        pc_redirect,
    output logic [29:0] redirect_pc,
    output logic [4:0]  exc_code,
    output logic        drain_timeout
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAIN = 3'd1,
        ENTER = 3'd2,
        REDIR = 3'd3,
        RET   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(DRAIN_TIMEOUT);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_exc_code;
    logic             r_drain_timeout;
    logic             w_timeout;

    assign w_timeout = (r_cnt == TIMEOUT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_exc_code      <= 5'd0;
            r_drain_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (exc_valid) begin
                        r_exc_code <= exc_code_in;
                        r_cnt      <= '0;
                        r_state    <= DRAIN;
                    end else if (int_req) begin
                        r_exc_code <= 5'd0;
                        r_cnt      <= '0;
                        r_state    <= DRAIN;
                    end else if (eret) begin
                        r_state <= RET;
                    end
                end
                DRAIN: begin
                    // A stuck bus must not hold off exception entry forever.
                    if (w_timeout) begin
                        r_drain_timeout <= 1'b1;
                        r_state         <= ENTER;
                    end else if (mem_idle) begin
                        r_state <= ENTER;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ENTER:   r_state <= REDIR;
                REDIR:   r_state <= IDLE;
                RET:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Moore decode only, so the async reset zeroes every output immediately.
    assign stall         = (r_state == DRAIN) || (r_state == ENTER) || (r_state == REDIR);
    assign flush         = (r_state == ENTER) || (r_state == RET);
    assign exl_set       = (r_state == ENTER);
    assign exl_clr       = (r_state == RET);
    assign pc_redirect   = (r_state == REDIR) || (r_state == RET);
    assign exc_code      = r_exc_code;
    assign drain_timeout = r_drain_timeout;

    always_comb begin
        redirect_pc = 30'd0;
        case (r_state)
            REDIR:   redirect_pc = HANDLER_PC;
            RET:     redirect_pc = epc;
            default: redirect_pc = 30'd0;
        endcase
    end

endmodule

// File: tb/tb_exc_sequencer.sv
// Scoreboard bench for exc_sequencer: expected output vectors are queued per scenario, popped each cycle.
module tb_exc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        int_req;
    logic        exc_valid;
    logic [4:0]  exc_code_in;
    logic        eret;
    logic        mem_idle;
    logic [29:0] epc;
    logic        stall;
    logic        flush;
    logic        exl_set;
    logic        exl_clr;
    logic        pc_redirect;
    logic [29:0] redirect_pc;
    logic [4:0]  exc_code;
    logic        drain_timeout;

    always #5 clk = ~clk;

    exc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .int_req       (int_req),
        .exc_valid     (exc_valid),
        .exc_code_in   (exc_code_in),
        .eret          (eret),
        .mem_idle      (mem_idle),
        .epc           (epc),
        .stall         (stall),
        .flush         (flush),
        .exl_set       (exl_set),
        .exl_clr       (exl_clr),
        .pc_redirect   (pc_redirect),
        .redirect_pc   (redirect_pc),
        .exc_code      (exc_code),
        .drain_timeout (drain_timeout)
    );

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        exl_set;
        logic        exl_clr;
        logic        pc_redirect;
        logic [29:0] rpc;
        logic [4:0]  code;
        logic        dto;
    } exp_t;

    // {stall, flush, exl_set, exl_clr, pc_redirect} per state
    localparam logic [4:0] S_IDLE  = 5'b00000;
    localparam logic [4:0] S_DRAIN = 5'b10000;
    localparam logic [4:0] S_ENTER = 5'b11100;
    localparam logic [4:0] S_REDIR = 5'b10001;
    localparam logic [4:0] S_RET   = 5'b01011;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic exp_t mk(input logic [4:0] st, input logic [29:0] rpc,
                                input logic [4:0] code, input logic dto);
        mk = {st, rpc, code, dto};
    endfunction

    function automatic exp_t obs();
        obs = {stall, flush, exl_set, exl_clr, pc_redirect, redirect_pc, exc_code, drain_timeout};
    endfunction

    task automatic test_reset();
        exp_t e, a;
        reset = 1'b1; int_req = 1'b0; exc_valid = 1'b0; exc_code_in = 5'd0;
        eret = 1'b0; mem_idle = 1'b1; epc = 30'd0;
        sb.push_back(mk(S_IDLE, 30'd0, 5'd0, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        e = sb.pop_front(); a = obs(); n_chk++;
        if (a !== e) begin n_fail++; $display("FAIL reset_hold: got %h want %h", a, e); end
        @(negedge clk);
        reset = 1'b0;
        sb.push_back(mk(S_IDLE, 30'd0, 5'd0, 1'b0));
        @(posedge clk);
        #1;
        e = sb.pop_front(); a = obs(); n_chk++;
        if (a !== e) begin n_fail++; $display("FAIL reset_release: got %h want %h", a, e); end
    endtask

    task automatic test_exc_entry();
        exp_t e, a;
        sb.push_back(mk(S_DRAIN, 30'd0,     5'd4, 1'b0));
        sb.push_back(mk(S_ENTER, 30'd0,     5'd4, 1'b0));
        sb.push_back(mk(S_REDIR, 30'h1060,  5'd4, 1'b0));
        sb.push_back(mk(S_IDLE,  30'd0,     5'd4, 1'b0));
        for (int k = 0; k < 4; k++) begin
            exc_valid   = (k == 0);
            exc_code_in = (k == 0) ? 5'd4 : 5'd9;
            mem_idle    = 1'b1;
            @(posedge clk);
            #1;
            e = sb.pop_front(); a = obs(); n_chk++;
            if (a !== e) begin n_fail++; $display("FAIL exc_entry cyc%0d: got %h want %h", k, a, e); end
        end
        exc_valid = 1'b0;
    endtask

    task automatic test_int_drain();
        exp_t e, a;
        repeat (4) sb.push_back(mk(S_DRAIN, 30'd0, 5'd0, 1'b0));
        sb.push_back(mk(S_ENTER, 30'd0,    5'd0, 1'b0));
        sb.push_back(mk(S_REDIR, 30'h1060, 5'd0, 1'b0));
        sb.push_back(mk(S_IDLE,  30'd0,    5'd0, 1'b0));
        for (int k = 0; k < 7; k++) begin
            int_req  = (k == 0);
            mem_idle = (k >= 4);
            @(posedge clk);
            #1;
            e = sb.pop_front(); a = obs(); n_chk++;
            if (a !== e) begin n_fail++; $display("FAIL int_drain cyc%0d: got %h want %h", k, a, e); end
        end
        int_req = 1'b0; mem_idle = 1'b1;
    endtask

    task automatic test_drain_timeout();
        exp_t e, a;
        repeat (16) sb.push_back(mk(S_DRAIN, 30'd0, 5'd12, 1'b0));
        sb.push_back(mk(S_ENTER, 30'd0,    5'd12, 1'b1));
        sb.push_back(mk(S_REDIR, 30'h1060, 5'd12, 1'b1));
        sb.push_back(mk(S_IDLE,  30'd0,    5'd12, 1'b1));
        for (int k = 0; k < 19; k++) begin
            exc_valid   = (k <= 17);
            exc_code_in = (k == 0) ? 5'd12 : 5'd7;
            mem_idle    = 1'b0;
            @(posedge clk);
            #1;
            e = sb.pop_front(); a = obs(); n_chk++;
            if (a !== e) begin n_fail++; $display("FAIL drain_timeout cyc%0d: got %h want %h", k, a, e); end
        end
        exc_valid = 1'b0; mem_idle = 1'b1;
    endtask

    task automatic test_eret();
        exp_t e, a;
        sb.push_back(mk(S_RET,  30'h0C00, 5'd12, 1'b1));
        sb.push_back(mk(S_RET,  30'h0155, 5'd12, 1'b1));
        sb.push_back(mk(S_IDLE, 30'd0,    5'd12, 1'b1));
        eret = 1'b1; epc = 30'h0C00;
        @(posedge clk);
        #1;
        e = sb.pop_front(); a = obs(); n_chk++;
        if (a !== e) begin n_fail++; $display("FAIL eret_ret: got %h want %h", a, e); end
        eret = 1'b0; epc = 30'h0155;
        #1;
        e = sb.pop_front(); a = obs(); n_chk++;
        if (a !== e) begin n_fail++; $display("FAIL eret_epc_comb: got %h want %h", a, e); end
        @(posedge clk);
        #1;
        e = sb.pop_front(); a = obs(); n_chk++;
        if (a !== e) begin n_fail++; $display("FAIL eret_idle: got %h want %h", a, e); end
    endtask

    task automatic test_exc_and_eret();
        exp_t e, a;
        sb.push_back(mk(S_DRAIN, 30'd0,    5'd8, 1'b1));
        sb.push_back(mk(S_ENTER, 30'd0,    5'd8, 1'b1));
        sb.push_back(mk(S_REDIR, 30'h1060, 5'd8, 1'b1));
        sb.push_back(mk(S_IDLE,  30'd0,    5'd8, 1'b1));
        for (int k = 0; k < 4; k++) begin
            exc_valid   = (k == 0);
            eret        = (k == 0);
            exc_code_in = 5'd8;
            mem_idle    = 1'b1;
            @(posedge clk);
            #1;
            e = sb.pop_front(); a = obs(); n_chk++;
            if (a !== e) begin n_fail++; $display("FAIL exc_and_eret cyc%0d: got %h want %h", k, a, e); end
        end
        exc_valid = 1'b0; eret = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e, a;
        sb.push_back(mk(S_DRAIN, 30'd0, 5'd3, 1'b1));
        sb.push_back(mk(S_ENTER, 30'd0, 5'd3, 1'b1));
        for (int k = 0; k < 2; k++) begin
            exc_valid   = (k == 0);
            exc_code_in = 5'd3;
            mem_idle    = 1'b1;
            @(posedge clk);
            #1;
            e = sb.pop_front(); a = obs(); n_chk++;
            if (a !== e) begin n_fail++; $display("FAIL mid_pre cyc%0d: got %h want %h", k, a, e); end
        end
        exc_valid = 1'b0;
        sb.push_back(mk(S_IDLE, 30'd0, 5'd0, 1'b0));
        sb.push_back(mk(S_IDLE, 30'd0, 5'd0, 1'b0));
        reset = 1'b1;
        #1;
        e = sb.pop_front(); a = obs(); n_chk++;
        if (a !== e) begin n_fail++; $display("FAIL mid_reset_immediate: got %h want %h", a, e); end
        @(posedge clk);
        #1;
        e = sb.pop_front(); a = obs(); n_chk++;
        if (a !== e) begin n_fail++; $display("FAIL mid_reset_held: got %h want %h", a, e); end
        @(negedge clk);
        reset = 1'b0; int_req = 1'b1; mem_idle = 1'b1;
        sb.push_back(mk(S_DRAIN, 30'd0,    5'd0, 1'b0));
        sb.push_back(mk(S_ENTER, 30'd0,    5'd0, 1'b0));
        sb.push_back(mk(S_REDIR, 30'h1060, 5'd0, 1'b0));
        sb.push_back(mk(S_IDLE,  30'd0,    5'd0, 1'b0));
        for (int k = 0; k < 4; k++) begin
            if (k > 0) int_req = 1'b0;
            @(posedge clk);
            #1;
            e = sb.pop_front(); a = obs(); n_chk++;
            if (a !== e) begin n_fail++; $display("FAIL mid_post_int cyc%0d: got %h want %h", k, a, e); end
        end
        int_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_exc_entry();
        test_int_drain();
        test_drain_timeout();
        test_eret();
        test_exc_and_eret();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/exc_sequencer.md
EXC_SEQUENCER -- requirements
Module: exc_sequencer

Interface
REQ-001 SHALL have parameter HANDLER_PC, default 30'h1060 (word address of handler entry 0x0000_4180).
REQ-002 SHALL have parameter DRAIN_TIMEOUT, default 15: maximum number of DRAIN cycles before forced entry.
REQ-003 SHALL have parameter CNT_W, default 4: drain counter width; DRAIN_TIMEOUT SHALL be < 2^CNT_W.
REQ-004 SHALL have ports:
- clk  in  1  clock; reset reset, asynchronous, active-high; clock clk.
- reset  in  1  asynchronous, active-high reset.
- int_req  in  1  interrupt request from the CP0 block.
- exc_valid  in  1  synchronous exception raised by the pipeline.
- exc_code_in  in  5  cause code accompanying exc_valid.
- eret  in  1  ERET decoded in the memory stage.
- mem_idle  in  1  no bus transaction in flight.
- epc  in  30  saved EPC word address from CP0.
- stall  out  1  freeze the pipeline front end.
- flush  out  1  kill all in-flight instructions.
- exl_set  out  1  one-cycle pulse to the CP0 EXLSet input.
- exl_clr  out  1  one-cycle pulse to the CP0 EXLClr input.
- pc_redirect  out  1  load the PC from redirect_pc.
- redirect_pc  out  30  target word address.
- exc_code  out  5  latched cause code.
- drain_timeout  out  1  sticky flag: a drain was forced.

Function
REQ-005 SHALL implement the states IDLE, DRAIN, ENTER, REDIR and RET in a single state register.
REQ-006 IDLE SHALL use priority exc_valid > int_req > eret.
REQ-007 On exc_valid in IDLE, SHALL latch exc_code_in into exc_code, clear the counter and go to DRAIN.
REQ-008 On int_req (with no exc_valid) in IDLE, SHALL latch exc_code = 5'd0, clear the counter and go to DRAIN.
REQ-009 On eret alone in IDLE, SHALL go to RET.
REQ-010 DRAIN SHALL go to ENTER when mem_idle=1, otherwise increment the counter.
REQ-011 When the counter equals DRAIN_TIMEOUT in DRAIN, SHALL go to ENTER regardless of mem_idle and set drain_timeout.
REQ-012 drain_timeout SHALL be cleared only by reset.
REQ-013 ENTER SHALL last exactly one cycle, then go to REDIR.
REQ-014 REDIR SHALL last exactly one cycle, then go to IDLE.
REQ-015 RET SHALL last exactly one cycle, then go to IDLE.
REQ-016 Outputs SHALL be Moore, decoded from the state register only:
- stall=1 in DRAIN, ENTER and REDIR.
- flush=1 in ENTER and RET.
- exl_set=1 in ENTER only.
- exl_clr=1 in RET only.
- pc_redirect=1 in REDIR and RET.
REQ-017 redirect_pc SHALL equal HANDLER_PC in REDIR, epc in RET, and 0 otherwise.
REQ-018 exl_set and exl_clr SHALL never be asserted in the same cycle.
REQ-019 Minimum latency from exc_valid sampled at edge N with mem_idle=1: ENTER in cycle N+2, pc_redirect in cycle N+3.
REQ-020 exc_valid, int_req and eret SHALL be ignored in every state other than IDLE.
REQ-021 exc_code SHALL hold its value until the next exception entry.
REQ-022 The counter SHALL saturate and never wrap.
REQ-023 epc SHALL be sampled combinationally during RET.

Reset
REQ-024 While reset=1, SHALL force the state to IDLE, the counter to 0, exc_code to 0 and drain_timeout to 0.
REQ-025 Reset SHALL force every output to 0, including when asserted mid-sequence.
REQ-026 After reset release, the first edge SHALL evaluate IDLE.

Verification
REQ-027 SHALL cover: exc_valid=1 with exc_code_in=5'd4 and mem_idle=1.
- Required: DRAIN, ENTER (exl_set=1, flush=1), REDIR (redirect_pc=30'h1060), then IDLE.
- Required: exc_code=4 and stall high for 3 cycles.
REQ-028 SHALL cover: int_req=1 with mem_idle=0 for 3 cycles, then 1.
- Required: 4 DRAIN cycles, then ENTER, with exc_code=0 and drain_timeout=0.
REQ-029 SHALL cover: exc_valid=1 with mem_idle held at 0.
- Required: ENTER on the 16th DRAIN cycle and drain_timeout=1 until reset.
REQ-030 SHALL cover: eret=1 with epc=30'h0C00.
- Required: one cycle with exl_clr=1, flush=1, pc_redirect=1 and redirect_pc=30'h0C00, then IDLE.
REQ-031 SHALL cover: exc_valid=1 and eret=1 in the same cycle.
- Required: exception entry and no exl_clr pulse.
REQ-032 SHALL cover: reset asserted during ENTER.
- Required: all outputs 0 immediately, state IDLE, and a later int_req handled normally.
